// File: rtl/microsequencer_if.sv
// Sequencing fields from the microstore into the microsequencer, and the
// registered microstate plus fault flag going back out.
interface microsequencer_if;
    logic [2:0] next_sel;
    logic       inv;
    logic [1:0] cond_sel;
    logic [6:0] cr_addr;
    logic [5:0] opcode;
    logic       moc;
    logic       cond;
    logic [6:0] state;
    logic       fault;

    // Fields are decoded from state combinationally and sampled on the next
    // rising edge; there is no valid/ready, every cycle is a transfer.
    modport master (
        output next_sel, inv, cond_sel, cr_addr, opcode, moc, cond,
        input  state, fault
    );

    modport slave (
        input  next_sel, inv, cond_sel, cr_addr, opcode, moc, cond,
        output state, fault
    );
endinterface

// File: rtl/microsequencer.sv
// Next-state generator for the microprogrammed control unit, with a
// hold-cycle watchdog that locks into FAULT_STATE until reset.
module microsequencer #(
    parameter int unsigned MOC_TIMEOUT = 15,
    parameter logic [6:0]  FAULT_STATE = 7'd31
) (
    input logic             clk,
    input logic             reset,
    microsequencer_if.slave bus
);
    localparam int unsigned   CW         = $clog2(MOC_TIMEOUT + 1);
    localparam logic [CW-1:0] HOLD_LIMIT = CW'(MOC_TIMEOUT);

    typedef enum logic {
        MODE_RUN   = 1'b0,
        MODE_FAULT = 1'b1
    } mode_t;

    mode_t         r_mode;
    logic [6:0]    r_state;
    logic [CW-1:0] r_hold_cnt;

    mode_t         w_mode_next;
    logic [6:0]    w_state_next;
    logic [CW-1:0] w_cnt_next;
    logic          w_raw;
    logic          w_ct;
    logic          w_hold;
    logic [6:0]    w_inc;
    logic [6:0]    w_enc;
    logic [6:0]    w_sel;

    assign w_inc = r_state + 7'd1;

    always_comb begin
        w_raw = 1'b0;
        case (bus.cond_sel)
            2'b00:   w_raw = bus.moc;
            2'b01:   w_raw = bus.cond;
            2'b10:   w_raw = 1'b1;
            default: w_raw = 1'b0;
        endcase
    end

    assign w_ct   = w_raw ^ bus.inv;
    assign w_hold = bus.next_sel[2] & bus.next_sel[1] & w_ct;

    always_comb begin
        w_enc = 7'd5;
        case (bus.opcode)
            6'h00:   w_enc = 7'd6;
            6'h23:   w_enc = 7'd7;
            6'h2B:   w_enc = 7'd8;
            6'h20:   w_enc = 7'd13;
            6'h04:   w_enc = 7'd16;
            6'h08:   w_enc = 7'd17;
            6'h0A:   w_enc = 7'd18;
            6'h0C:   w_enc = 7'd19;
            6'h0D:   w_enc = 7'd20;
            6'h0F:   w_enc = 7'd21;
            6'h02:   w_enc = 7'd22;
            6'h0E:   w_enc = 7'd23;
            default: w_enc = 7'd5;
        endcase
    end

    // Hold cases (110/111 with ct set) are handled by the watchdog path, so
    // only their not-taken targets appear here.
    always_comb begin
        w_sel = w_inc;
        case (bus.next_sel)
            3'b000:  w_sel = w_enc;
            3'b001:  w_sel = 7'd0;
            3'b010:  w_sel = bus.cr_addr;
            3'b011:  w_sel = w_inc;
            3'b100:  w_sel = w_ct ? bus.cr_addr : w_inc;
            3'b101:  w_sel = w_ct ? bus.cr_addr : w_enc;
            3'b110:  w_sel = w_inc;
            default: w_sel = bus.cr_addr;
        endcase
    end

    always_comb begin
        w_mode_next  = r_mode;
        w_state_next = r_state;
        w_cnt_next   = '0;
        case (r_mode)
            MODE_FAULT: w_state_next = FAULT_STATE;
            default: begin
                if (w_hold) begin
                    if (r_hold_cnt == HOLD_LIMIT) begin
                        w_mode_next  = MODE_FAULT;
                        w_state_next = FAULT_STATE;
                    end else begin
                        w_cnt_next = r_hold_cnt + 1'b1;
                    end
                end else begin
                    w_state_next = w_sel;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode     <= MODE_RUN;
            r_state    <= 7'd0;
            r_hold_cnt <= '0;
        end else begin
            r_mode     <= w_mode_next;
            r_state    <= w_state_next;
            r_hold_cnt <= w_cnt_next;
        end
    end

    assign bus.state = r_state;
    assign bus.fault = (r_mode == MODE_FAULT);
endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer: a table-driven reference model checked
// every cycle, plus literal expectations along the test plan.
module tb_microsequencer;
    logic clk;
    logic reset;
    microsequencer_if bus ();

    microsequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;
    bit chk_en;

    logic [6:0] enc_tab [64];
    logic [6:0] m_state;
    logic       m_fault;
    int         m_holds;

    task automatic check(input string nm, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Reference: pick the "taken" or "not taken" target from a per-field
    // table, then apply the watchdog rule by counting consecutive holds.
    task automatic model_next(output logic [6:0] ns, output logic nf, output int nh);
        logic [1:0] cs;
        logic       raw;
        logic       ct;
        int         src;
        logic [6:0] pick [4];
        int         taken_src [8];
        int         other_src [8];
        cs = bus.cond_sel;
        raw = (cs == 2'd0) ? bus.moc : (cs == 2'd1) ? bus.cond : (cs == 2'd2);
        ct = raw ^ bus.inv;
        // sources: 0 encoder, 1 fetch, 2 cr_addr, 3 inc, -1 hold
        taken_src = '{0, 1, 2, 3, 2, 2, -1, -1};
        other_src = '{0, 1, 2, 3, 3, 0, 3, 2};
        pick[0] = enc_tab[bus.opcode];
        pick[1] = 7'd0;
        pick[2] = bus.cr_addr;
        pick[3] = 7'((m_state + 1) % 128);
        src = ct ? taken_src[bus.next_sel] : other_src[bus.next_sel];
        ns = m_state;
        nf = m_fault;
        nh = 0;
        if (reset) begin
            ns = 7'd0;
            nf = 1'b0;
        end else if (m_fault) begin
            ns = 7'd31;
        end else if (src < 0) begin
            if (m_holds == 15) begin
                ns = 7'd31;
                nf = 1'b1;
            end else begin
                nh = m_holds + 1;
            end
        end else begin
            ns = pick[src];
        end
    endtask

    always @(posedge clk) begin
        logic [6:0] ns;
        logic       nf;
        int         nh;
        model_next(ns, nf, nh);
        m_state <= ns;
        m_fault <= nf;
        m_holds <= nh;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_state", int'(bus.state), int'(m_state));
            check("model_fault", int'(bus.fault), int'(m_fault));
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] ns, input logic iv, input logic [1:0] cs,
                         input logic [6:0] cr, input logic [5:0] op, input logic mc,
                         input logic cd);
        bus.next_sel = ns;
        bus.inv      = iv;
        bus.cond_sel = cs;
        bus.cr_addr  = cr;
        bus.opcode   = op;
        bus.moc      = mc;
        bus.cond     = cd;
    endtask

    task automatic expect_lit(input string nm, input int st, input int flt);
        check({nm, "_state"}, int'(bus.state), st);
        check({nm, "_fault"}, int'(bus.fault), flt);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        chk_en  = 1'b0;
        m_state = 7'd0;
        m_fault = 1'b0;
        m_holds = 0;
        for (int i = 0; i < 64; i++) enc_tab[i] = 7'd5;
        enc_tab[6'h00] = 7'd6;  enc_tab[6'h23] = 7'd7;  enc_tab[6'h2B] = 7'd8;
        enc_tab[6'h20] = 7'd13; enc_tab[6'h04] = 7'd16; enc_tab[6'h08] = 7'd17;
        enc_tab[6'h0A] = 7'd18; enc_tab[6'h0C] = 7'd19; enc_tab[6'h0D] = 7'd20;
        enc_tab[6'h0F] = 7'd21; enc_tab[6'h02] = 7'd22; enc_tab[6'h0E] = 7'd23;

        reset = 1'b1;
        drive(3'b011, 1'b0, 2'b00, 7'd0, 6'h00, 1'b0, 1'b0);
        cyc();
        cyc();
        expect_lit("reset", 0, 0);
        chk_en = 1'b1;

        reset = 1'b0;
        cyc(); expect_lit("inc1", 1, 0);
        cyc(); expect_lit("inc2", 2, 0);
        cyc(); expect_lit("inc3", 3, 0);
        reset = 1'b1;
        cyc(); expect_lit("mid_reset", 0, 0);
        reset = 1'b0;
        cyc();
        cyc(); expect_lit("reinc", 2, 0);

        drive(3'b000, 1'b0, 2'b00, 7'd0, 6'h23, 1'b0, 1'b0);
        cyc(); expect_lit("enc_23", 7, 0);
        bus.opcode = 6'h0F;
        cyc(); expect_lit("enc_0f", 21, 0);
        bus.opcode = 6'h3F;
        cyc(); expect_lit("enc_illegal", 5, 0);
        drive(3'b101, 1'b0, 2'b01, 7'd40, 6'h2B, 1'b0, 1'b1);
        cyc(); expect_lit("ct_cr", 40, 0);
        bus.inv = 1'b1;
        cyc(); expect_lit("ct_inv_enc", 8, 0);

        drive(3'b110, 1'b1, 2'b00, 7'd0, 6'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(); expect_lit("moc_wait", 8, 0);
        end
        bus.moc = 1'b1;
        cyc(); expect_lit("moc_done", 9, 0);

        bus.moc = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cyc(); expect_lit("wd_hold", 9, 0);
        end
        cyc(); expect_lit("wd_expire", 31, 1);
        drive(3'b010, 1'b0, 2'b10, 7'd100, 6'h00, 1'b0, 1'b0);
        cyc(); expect_lit("lock_cr", 31, 1);
        bus.next_sel = 3'b011;
        cyc(); expect_lit("lock_inc", 31, 1);
        reset = 1'b1;
        cyc(); expect_lit("fault_reset", 0, 0);
        reset = 1'b0;

        drive(3'b010, 1'b0, 2'b00, 7'd127, 6'h00, 1'b0, 1'b0);
        cyc(); expect_lit("cr127", 127, 0);
        bus.next_sel = 3'b011;
        cyc(); expect_lit("wrap", 0, 0);
        drive(3'b010, 1'b0, 2'b00, 7'd31, 6'h00, 1'b0, 1'b0);
        cyc(); expect_lit("cr31", 31, 0);
        bus.next_sel = 3'b011;
        cyc(); expect_lit("past31", 32, 0);

        drive(3'b110, 1'b1, 2'b00, 7'd0, 6'h00, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) cyc();
        expect_lit("limit_hold", 32, 0);
        bus.moc = 1'b1;
        cyc(); expect_lit("limit_release", 33, 0);

        drive(3'b111, 1'b0, 2'b11, 7'd50, 6'h00, 1'b0, 1'b0);
        cyc(); expect_lit("n111_cr", 50, 0);
        drive(3'b100, 1'b0, 2'b10, 7'd60, 6'h00, 1'b0, 1'b0);
        cyc(); expect_lit("n100_cr", 60, 0);
        drive(3'b100, 1'b1, 2'b01, 7'd70, 6'h00, 1'b0, 1'b0);
        cyc(); expect_lit("n100_inv", 70, 0);
        drive(3'b111, 1'b0, 2'b10, 7'd5, 6'h00, 1'b0, 1'b0);
        cyc(); expect_lit("n111_hold", 70, 0);
        drive(3'b001, 1'b0, 2'b00, 7'd5, 6'h00, 1'b0, 1'b0);
        cyc(); expect_lit("fetch", 0, 0);

        drive(3'b110, 1'b1, 2'b00, 7'd0, 6'h00, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) cyc();
        reset = 1'b1;
        cyc(); expect_lit("reset_on_expiry", 0, 0);
        reset = 1'b0;
        cyc();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
